// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, state type and helpers for the RV32M multiply/divide unit
//
// Contents:
//   MD_*_OP      RV32M funct3 encodings
//   MD_ITERS     radix-2 iterations per operation
//   md_state_t   control FSM states
//   md_a_signed / md_b_signed  operand signedness per funct3
//   md_abs       conditional two's-complement magnitude

package muldiv_pkg;

   localparam logic [2:0] MD_MUL_OP    = 3'd0;
   localparam logic [2:0] MD_MULH_OP   = 3'd1;
   localparam logic [2:0] MD_MULHSU_OP = 3'd2;
   localparam logic [2:0] MD_MULHU_OP  = 3'd3;
   localparam logic [2:0] MD_DIV_OP    = 3'd4;
   localparam logic [2:0] MD_DIVU_OP   = 3'd5;
   localparam logic [2:0] MD_REM_OP    = 3'd6;
   localparam logic [2:0] MD_REMU_OP   = 3'd7;

   localparam int unsigned MD_ITERS    = 32;
   localparam logic [4:0]  MD_CNT_INIT = 5'(MD_ITERS - 1);

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_t;

   function automatic logic md_a_signed(input logic [2:0] f);
      return (f == MD_MULH_OP) || (f == MD_MULHSU_OP) || (f == MD_DIV_OP) || (f == MD_REM_OP);
   endfunction

   function automatic logic md_b_signed(input logic [2:0] f);
      return (f == MD_MULH_OP) || (f == MD_DIV_OP) || (f == MD_REM_OP);
   endfunction

   function automatic logic [31:0] md_abs(input logic [31:0] x, input logic is_signed);
      return (is_signed && x[31]) ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational radix-2 shift-add / restoring-divide iteration
//
// Ports:
//   acc_i   upper product accumulator (multiply) or partial remainder (divide)
//   lsb_i   multiply: current multiplier bit; divide: next dividend bit shifted in
//   opnd_i  multiplicand or divisor magnitude
//   div_i   1 = divide iteration, 0 = multiply iteration
//   acc_o   next accumulator / partial remainder
//   bit_o   multiply: bit shifted into the low product word; divide: quotient bit

module muldiv_step (
   input  logic [31:0] acc_i,
   input  logic        lsb_i,
   input  logic [31:0] opnd_i,
   input  logic        div_i,
   output logic [31:0] acc_o,
   output logic        bit_o
);

   logic [32:0] sum;
   logic [32:0] rem_shift;
   logic [32:0] diff;

   always_comb begin
      sum       = lsb_i ? ({1'b0, acc_i} + {1'b0, opnd_i}) : {1'b0, acc_i};
      rem_shift = {acc_i, lsb_i};
      // The partial remainder is always below the divisor, so the shifted
      // value is below 2*divisor: bit 32 of the 33-bit difference is set
      // exactly when the trial subtract would go negative.
      diff      = rem_shift - {1'b0, opnd_i};
      if (div_i) begin
         if (!diff[32]) begin
            acc_o = diff[31:0];
            bit_o = 1'b1;
         end else begin
            acc_o = rem_shift[31:0];
            bit_o = 1'b0;
         end
      end else begin
         acc_o = sum[32:1];
         bit_o = sum[0];
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (32 radix-2 iterations + sign fix)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operation handshake; in_ready is high only while idle
//   op, a, b              RV32M funct3 and rs1/rs2 operands
//   kill                  synchronous abort, highest priority
//   out_valid / out_ready result handshake; result held stable while out_valid
//   result                operation result
//
// Optional feature macro: MULDIV_FAST_PATH_EN - divide by zero and multiply by
// zero skip the iteration phase and go straight to FIX.

module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        kill,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   md_state_t   state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] acc_q, acc_d;     // product high word / partial remainder
   logic [31:0] low_q, low_d;     // product low word (multiplier) / dividend->quotient
   logic [31:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
   logic        neg_q, neg_d;     // final result must be negated
   logic        bzero_q, bzero_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        out_valid_q, out_valid_d;

   logic        sign_a, sign_b;
   logic [31:0] mag_a, mag_b;
   logic        step_div;
   logic        step_lsb;
   logic [31:0] step_acc;
   logic        step_bit;
   logic [63:0] prod, prod_fix;
   logic [31:0] quo_fix, rem_fix;
   logic [31:0] fix_result;

   assign sign_a = md_a_signed(op) & a[31];
   assign sign_b = md_b_signed(op) & b[31];
   assign mag_a  = md_abs(a, md_a_signed(op));
   assign mag_b  = md_abs(b, md_b_signed(op));

   assign step_div = op_q[2];
   assign step_lsb = step_div ? low_q[31] : low_q[0];

   muldiv_step u_step (
      .acc_i  (acc_q),
      .lsb_i  (step_lsb),
      .opnd_i (opnd_q),
      .div_i  (step_div),
      .acc_o  (step_acc),
      .bit_o  (step_bit)
   );

   assign prod     = {acc_q, low_q};
   assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
   assign quo_fix  = neg_q ? (~low_q + 32'd1) : low_q;
   assign rem_fix  = neg_q ? (~acc_q + 32'd1) : acc_q;

   // Divide by zero: low_q was loaded with the raw dividend and frozen, so the
   // remainder is the original a without any sign fix.
   always_comb begin
      fix_result = prod_fix[31:0];
      case (op_q)
         MD_MUL_OP:                            fix_result = prod_fix[31:0];
         MD_MULH_OP, MD_MULHSU_OP, MD_MULHU_OP: fix_result = prod_fix[63:32];
         MD_DIV_OP, MD_DIVU_OP:                fix_result = bzero_q ? 32'hFFFF_FFFF : quo_fix;
         default:                              fix_result = bzero_q ? low_q : rem_fix;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      low_d       = low_q;
      opnd_d      = opnd_q;
      neg_d       = neg_q;
      bzero_d     = bzero_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;

      case (state_q)
         MD_IDLE: begin
            if (in_valid && !kill) begin
               op_d    = op;
               bzero_d = (b == 32'd0);
               acc_d   = 32'd0;
               cnt_d   = MD_CNT_INIT;
               state_d = MD_CALC;
               if (op[2]) begin
                  low_d  = (b == 32'd0) ? a : mag_a;
                  opnd_d = mag_b;
                  neg_d  = op[1] ? sign_a : (sign_a ^ sign_b);
               end else begin
                  low_d  = mag_b;
                  opnd_d = mag_a;
                  neg_d  = sign_a ^ sign_b;
               end
`ifdef MULDIV_FAST_PATH_EN
               if (op[2] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0))) begin
                  state_d = MD_FIX;
                  // Zero product regardless of which operand was zero.
                  if (!op[2]) begin
                     low_d = 32'd0;
                  end
               end
`endif
            end
         end
         MD_CALC: begin
            if (!(op_q[2] && bzero_q)) begin
               acc_d = step_acc;
               low_d = op_q[2] ? {low_q[30:0], step_bit} : {step_bit, low_q[31:1]};
            end
            if (cnt_q == 5'd0) begin
               state_d = MD_FIX;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         MD_FIX: begin
            result_d    = fix_result;
            out_valid_d = 1'b1;
            state_d     = MD_DONE;
         end
         MD_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = MD_IDLE;
            end
         end
         default: state_d = MD_IDLE;
      endcase

      if (kill) begin
         state_d     = MD_IDLE;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= MD_IDLE;
         op_q        <= 3'd0;
         acc_q       <= 32'd0;
         low_q       <= 32'd0;
         opnd_q      <= 32'd0;
         neg_q       <= 1'b0;
         bzero_q     <= 1'b0;
         cnt_q       <= 5'd0;
         result_q    <= 32'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         low_q       <= low_d;
         opnd_q      <= opnd_d;
         neg_q       <= neg_d;
         bzero_q     <= bzero_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == MD_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the execute stage. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation per handshake and computes it over 32 radix-2 iterations (shift-add / restoring division on operand magnitudes) with a final sign-fix step. Execute stalls on `in_ready`/`out_valid`, and pipeline flushes abort it via `kill`.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit idle and able to accept.
- `op` in 3: RV32M funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
- `a`, `b` in 32: rs1, rs2 operands.
- `kill` in 1: synchronous abort, highest priority.
- `out_valid` out 1: `result` valid.
- `out_ready` in 1: consumer accepts result.
- `result` out 32: operation result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: `in_ready`=1. When `in_valid` is high and `kill` is low, latch op, operand magnitudes (signed ops only; MULHSU treats only `a` as signed), result sign and the `b==0` flag. Load iteration counter = 31 and go to CALC.
- CALC: one iteration per cycle.
  - Multiply: 33-bit add into the upper accumulator, then shift the 64-bit product right.
  - Divide: 33-bit trial subtract of divisor from partial remainder, then shift the quotient bit in.
  - Counter 0 → FIX.
- FIX: negate if the latched sign requires it. Select the result:
  - low product for MUL;
  - high product for MULH*;
  - quotient for DIV*;
  - remainder for REM*.
  - Register it into `result`, set `out_valid`, go to DONE.
- DONE: hold `result` and `out_valid` stable until `out_ready`=1, then go to IDLE.
- Special results, independent of the algorithm:
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = original `a`, with no sign fix.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. The magnitude algorithm yields this naturally; verify it explicitly.
- Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a). Both apply only for the signed ops.
- `kill` in any state → IDLE next cycle and `out_valid` cleared. `kill` together with `in_valid` in IDLE: no accept.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, counter 0.
- Accept at cycle N, then CALC for cycles N+1..N+32 and FIX at N+33. `out_valid` is first high in N+34, so latency is 34 cycles.
- `in_ready` is combinational from state (IDLE only). The earliest next accept is the cycle after the DONE handshake, giving 35-cycle throughput.
- `out_valid` is registered. `result` must not change while `out_valid`=1.
- Reset asserted mid-operation: the unit returns to reset values immediately and produces no result.

## Configuration
- `MULDIV_FAST_PATH_EN` defined:
  - DIV*/REM* with `b==0`, and MUL* with `a==0` or `b==0`, skip CALC and go straight to FIX.
  - `out_valid` then rises at N+2.
  - Results are identical to the slow path.
- Not defined: every operation takes the 34-cycle path. The zero-detect logic is absent.

## Structure
- Shared defines package gains `MD_*_OP` funct3 constants, a `md_state_t` enum and `MD_ITERS` = 32.
- Sub-module `muldiv_step` (combinational): one iteration. Inputs: accumulator/remainder, multiplicand/divisor, mode. Outputs: next accumulator/remainder and quotient bit.
- Top-level holds the FSM, counter, operand/sign registers and the FIX negation.

## Test plan
- MUL a=7, b=0xFFFFFFFD → `result`=0xFFFFFFEB, `out_valid` first high at N+34. MULHU same operands → 0x00000006.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. DIV 5/0 → 0xFFFFFFFF. REM 0xFFFFFFFB/0 → 0xFFFFFFFB. Latency is 34 without the macro and 2 with it.
- `kill` at N+10 → `out_valid` never rises and `in_ready`=1 at N+11. A new MUL 3×4 accepted at N+11 → 12 at N+45.
- `out_ready` held low 5 cycles after `out_valid` → `result` stable and `in_ready`=0 throughout. `rst_n` low mid-CALC → all outputs at reset values asynchronously.
